// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (optional MC_CTRL_HALT_ON_ILLEGAL_EN halts on undefined instructions)
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_we,
  output logic       pc_we,
  output logic       branch,
  output logic       jal,
  output logic       jr,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] ext_op,
  output logic [1:0] alu_op,
  output logic       mem_we,
  output logic       illegal,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;
`ifdef MC_CTRL_HALT_ON_ILLEGAL_EN
  localparam logic halt_en = 1'b1;
`else
  localparam logic halt_en = 1'b0;
`endif
  state_t cur, nxt;
  logic done;
  logic d_addu, d_subu, d_jr, d_ori, d_lui, d_lw, d_sw, d_beq, d_jal, d_und;
  logic unused_zero;
  // zero only steers the next-PC unit together with branch; the FSM path of beq does not depend on it
  assign unused_zero = zero;
  assign d_addu = op == 6'h00 && funct == 6'h21;
  assign d_subu = op == 6'h00 && funct == 6'h23;
  assign d_jr   = op == 6'h00 && funct == 6'h08;
  assign d_ori  = op == 6'h0D;
  assign d_lui  = op == 6'h0F;
  assign d_lw   = op == 6'h23;
  assign d_sw   = op == 6'h2B;
  assign d_beq  = op == 6'h04;
  assign d_jal  = op == 6'h03;
  assign d_und  = !(d_addu || d_subu || d_jr || d_ori || d_lui || d_lw || d_sw || d_beq || d_jal);
  // next state and the "this is the instruction's final state" flag that drives pc_we
  always_comb begin
    nxt  = S_IF;
    done = 1'b0;
    case (cur)
      S_IF:   nxt = S_ID;
      S_ID: begin
        done = d_jr || (d_und && !halt_en);
        nxt  = d_jal ? S_WB : d_jr ? S_IF : d_und ? (halt_en ? S_HALT : S_IF) : S_EXE;
      end
      S_EXE: begin
        done = d_beq;
        nxt  = d_beq ? S_IF : (d_lw || d_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        done = d_sw;
        nxt  = d_sw ? S_IF : S_WB;
      end
      S_WB: begin
        done = 1'b1;
        nxt  = S_IF;
      end
      S_HALT: nxt = halt_en ? S_HALT : S_IF;
      default: nxt = S_IF;
    endcase
  end
  // state register; stall freezes it, reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_IF;
    else if (!stall) cur <= nxt;
  end
  // per-state controls; enables are gated by stall, selects are not
  always_comb begin
    ir_we   = cur == S_IF && !stall;
    pc_we   = done && !stall;
    branch  = cur == S_EXE && d_beq;
    jal     = cur == S_WB && d_jal;
    jr      = cur == S_ID && d_jr;
    reg_we  = cur == S_WB && !stall;
    reg_dst = cur != S_WB ? 2'd0 : (d_addu || d_subu) ? 2'd1 : d_jal ? 2'd2 : 2'd0;
    wd_sel  = cur != S_WB ? 2'd0 : d_lw ? 2'd1 : d_jal ? 2'd2 : 2'd0;
    alu_src = cur == S_EXE && (d_ori || d_lui || d_lw || d_sw);
    ext_op  = cur != S_EXE ? 2'd0 : d_lui ? 2'd2 : (d_lw || d_sw || d_beq) ? 2'd1 : 2'd0;
    alu_op  = cur != S_EXE ? 2'd0 : (d_subu || d_beq) ? 2'd1 : d_ori ? 2'd2 : 2'd0;
    mem_we  = cur == S_MEM && d_sw && !stall;
    illegal = halt_en && cur == S_HALT;
    state   = cur;
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences each instruction through IF/ID/EXE/MEM/WB and drives the next-PC unit (`branch`, `jal`, `jr`, `pc_we`), the IR, register file, ALU and data memory. `pc_we` is asserted exactly once per instruction, in that instruction's final state, so the next-PC unit always sees the current PC.

## Interface
Parameters:
- None. Encodings are fixed.

Ports:
- `clk`  in  1  clock; all state updates occur on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to IF.
- `stall`  in  1  holds the FSM in its current state and gates every write enable to 0.
- `op`  in  6  IR[31:26]; valid from ID onward.
- `funct`  in  6  IR[5:0]; valid from ID onward.
- `zero`  in  1  ALU zero flag; sampled in EXE of `beq`.
- `ir_we`  out  1  instruction register write enable.
- `pc_we`  out  1  PC write enable.
- `branch`, `jal`, `jr`  out  1 each  next-PC unit selects.
- `reg_we`  out  1  register file write enable.
- `reg_dst`  out  2  write register select: 0 = rt, 1 = rd, 2 = $31.
- `wd_sel`  out  2  write-data select: 0 = ALU, 1 = memory, 2 = PC+4.
- `alu_src`  out  1  ALU B operand: 0 = rt, 1 = extended immediate.
- `ext_op`  out  2  immediate extension: 0 = zero, 1 = sign, 2 = upper (`lui`).
- `alu_op`  out  2  ALU function: 0 = add, 1 = sub, 2 = or.
- `mem_we`  out  1  data memory write enable.
- `illegal`  out  1  undefined instruction indicator (see Configuration).
- `state`  out  3  current state, for debug.

## Operation
- State encodings: IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, HALT = 5. Codes 6 and 7 go to IF on the next edge.
- Decoded instruction classes:
  - R-type (op 0x00): `addu` (funct 0x21), `subu` (0x23), `jr` (0x08).
  - I-type: `ori` 0x0D, `lui` 0x0F, `lw` 0x23, `sw` 0x2B, `beq` 0x04.
  - J-type: `jal` 0x03.
  - Any other op, or any other funct under op 0x00, is undefined.
- Instruction paths (the state marked with * asserts `pc_we`):
  - `addu`, `subu`, `ori`, `lui`: IF, ID, EXE, WB* (4 cycles).
  - `lw`: IF, ID, EXE, MEM, WB* (5 cycles).
  - `sw`: IF, ID, EXE, MEM* (4 cycles).
  - `beq`: IF, ID, EXE* (3 cycles).
  - `jal`: IF, ID, WB* (3 cycles).
  - `jr`: IF, ID* (2 cycles).
  - undefined: IF, ID* (2 cycles, PC+4).
- Next-PC selects:
  - `branch` = 1 in EXE of `beq`.
  - `jal` = 1 in WB of `jal`.
  - `jr` = 1 in ID of `jr`.
  - All are 0 in every other state.
- Datapath controls per state:
  - IF: `ir_we` = 1.
  - ID: `jr` and undefined instructions complete here.
  - EXE: drives `alu_op` / `alu_src` / `ext_op` for the instruction. `beq` uses sub with rt (ALU B = rt).
  - MEM: `mem_we` = 1 for `sw`.
  - WB: `reg_we` = 1. `reg_dst` is rd for R-type, rt for I-type, $31 for `jal`. `wd_sel` is 1 for `lw` and 2 for `jal`.
- Control outputs are combinational from state, `op` and `funct`. Outside the states listed above they are 0.
- With `stall` = 1:
  - `ir_we`, `pc_we`, `reg_we` and `mem_we` are 0.
  - Selects keep their decoded values.
  - The state register holds.
- Reset (asserted at any time, including mid-instruction) puts the FSM in IF. The partially executed instruction is abandoned: no PC, register or memory write is issued for it.

## Timing
- While `reset` = 1: `state` = 0, `ir_we` = !`stall`, and every other output is 0 (`illegal` = 0).
- One state transition per unstalled clock edge.
- A PC update takes effect on the edge that ends the `pc_we` state; the next cycle is IF.
- `zero` is used combinationally in the EXE cycle of `beq` only.
- `stall` is sampled every edge. Deasserting it resumes from the held state with no lost cycle.

## Configuration
- `MC_CTRL_HALT_ON_ILLEGAL_EN` defined:
  - An undefined instruction in ID goes to HALT instead of completing.
  - HALT asserts `illegal` = 1 and keeps all enables at 0.
  - HALT is left only by `reset`.
- Not defined:
  - Undefined instructions execute as a 2-cycle NOP (PC+4).
  - `illegal` is tied to 0 and the HALT state is unreachable.

## Test plan
- `reset` pulse, then `op` = 0x00, `funct` = 0x21: `state` sequence 0,1,2,4,0. In the WB cycle `reg_we` = 1, `reg_dst` = 1, `pc_we` = 1.
- `lw` (0x23): 5 cycles. WB has `wd_sel` = 1, `reg_dst` = 0, `pc_we` = 1. `sw` (0x2B): `mem_we` = 1 and `pc_we` = 1 in MEM, and `reg_we` is never 1.
- `beq` with `zero` = 1, then with `zero` = 0: both take 3 cycles, and EXE has `branch` = 1, `alu_op` = 1, `pc_we` = 1. `jal`: `jal` = 1, `reg_dst` = 2, `wd_sel` = 2 in WB. `jr`: `jr` = 1 and `pc_we` = 1 in ID.
- `stall` = 1 for 3 cycles during MEM of `lw`: `state` holds at 3 and all write enables are 0. After release, WB follows and the total is 8 cycles.
- `reset` asserted asynchronously mid-EXE of `ori`: `state` = 0 immediately, and no `reg_we` or `pc_we` is issued for that `ori`.
- `op` = 0x3F:
  - With the macro: `state` goes 0, 1, 5 and stays at 5, `illegal` = 1, `pc_we` stays 0.
  - Without the macro: 2 cycles with `pc_we` = 1 in ID, and `illegal` = 0.
